// File: rtl/fp16_to_int_if.sv
// Handshake and data bundle for the binary16 -> int16 converter.
// master = producer/consumer side (testbench or upstream logic),
// slave  = the converter itself.
interface fp16_to_int_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic        rm;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        invalid;
  logic        inexact;

  modport master (
    output in_valid, x, rm, out_ready,
    input  in_ready, out_valid, result, invalid, inexact
  );

  modport slave (
    input  in_valid, x, rm, out_ready,
    output in_ready, out_valid, result, invalid, inexact
  );
endinterface

// File: rtl/fp16_to_int.sv
// Multi-cycle IEEE-754 binary16 to signed int16 converter.
// The operand's significand is loaded into a 27-bit accumulator and shifted
// left one bit per cycle by the unbiased exponent; a single ROUND cycle then
// applies truncation or round-to-nearest-even, the sign and saturation.
module fp16_to_int (
  input logic          clk,
  input logic          reset_n,
  fp16_to_int_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  state_t      r_state;
  state_t      w_next;

  logic [15:0] r_x;
  logic        r_rm;
  logic [26:0] r_acc;
  logic [3:0]  r_cnt;
  logic [15:0] r_result;
  logic        r_invalid;
  logic        r_inexact;
  logic        r_out_valid;

  logic        w_in_ready;
  logic        w_accept;
  logic [4:0]  w_exp;
  logic        w_do_shift;

  logic        w_sign;
  logic [4:0]  w_rexp;
  logic [9:0]  w_frac;
  logic [15:0] w_int;
  logic        w_lsb;
  logic        w_guard;
  logic        w_sticky;
  logic        w_inc;
  logic [15:0] w_mag;
  logic        w_sat;
  logic        w_sat_neg;
  logic        w_invalid;
  logic        w_inexact;
  logic [15:0] w_result;

  assign w_in_ready = (r_state == IDLE);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_exp      = bus.x[14:10];
  // Only 1 <= E <= 14 (exp 16..29) needs shifting; everything else rounds directly.
  assign w_do_shift = (w_exp >= 5'd16) && (w_exp <= 5'd29);

  assign w_sign   = r_x[15];
  assign w_rexp   = r_x[14:10];
  assign w_frac   = r_x[9:0];
  assign w_int    = r_acc[26:11];
  assign w_lsb    = r_acc[11];
  assign w_guard  = r_acc[10];
  assign w_sticky = |r_acc[9:0];
  assign w_inc    = r_rm && w_guard && (w_sticky || w_lsb);

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.invalid   = r_invalid;
  assign bus.inexact   = r_inexact;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no branch leaves w_next unassigned (no inferred latch).
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_next = w_do_shift ? SHIFT : ROUND;
      SHIFT: if (r_cnt == 4'd1) w_next = ROUND;
      ROUND: w_next = DONE;
      DONE:  if (r_out_valid && bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Rounding, sign and saturation evaluated from the accumulator and captured operand.
  always_comb begin
    w_mag     = '0;
    w_sat     = 1'b0;
    w_sat_neg = 1'b0;
    w_invalid = 1'b0;
    w_inexact = 1'b0;
    if (w_rexp == 5'd31) begin
      // Infinity saturates by sign; any NaN saturates positive.
      w_sat     = 1'b1;
      w_sat_neg = w_sign && (w_frac == 10'd0);
      w_invalid = 1'b1;
    end else if (w_rexp == 5'd0) begin
      w_inexact = |w_frac;
    end else if (w_rexp < 5'd15) begin
      // |x| < 1: only values above one half can round up, and only in nearest mode.
      w_inexact = 1'b1;
      if (r_rm && (w_rexp == 5'd14) && (w_frac != 10'd0)) w_mag = 16'd1;
    end else if (w_rexp >= 5'd30) begin
      // |x| >= 32768: only -32768 itself is representable.
      w_sat     = 1'b1;
      w_sat_neg = w_sign;
      w_invalid = (r_x != 16'hF800);
    end else begin
      w_mag     = w_int + {15'd0, w_inc};
      w_inexact = w_guard || w_sticky;
    end

    if (w_sat) w_result = w_sat_neg ? 16'h8000 : 16'h7FFF;
    else       w_result = w_sign ? (~w_mag + 16'd1) : w_mag;
  end

  // Datapath: operand capture, shifting, result registers and output valid.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: datapath registers are reset too, since reset must leave result/flags at zero.
      r_x         <= '0;
      r_rm        <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_invalid   <= 1'b0;
      r_inexact   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_x   <= bus.x;
            r_rm  <= bus.rm;
            r_acc <= {15'd0, 1'b1, bus.x[9:0], 1'b0};
            r_cnt <= w_do_shift ? 4'(w_exp - 5'd15) : 4'd0;
          end
        end
        SHIFT: begin
          r_acc <= {r_acc[25:0], 1'b0};
          r_cnt <= r_cnt - 4'd1;
        end
        ROUND: begin
          r_result  <= w_result;
          r_invalid <= w_invalid;
          r_inexact <= w_inexact;
        end
        DONE: begin
          // Valid rises one edge into DONE and drops on the consuming edge.
          r_out_valid <= !(r_out_valid && bus.out_ready);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fp16_to_int.md
FP16_TO_INT -- requirements
Module: fp16_to_int

Interface
REQ-001 No parameters; the block SHALL be fixed to IEEE-754 binary16 input and two's-complement int16 output.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 in_valid  input  1  operand x is presented.
REQ-005 in_ready  output  1  block can accept an operand; high only in IDLE.
REQ-006 x  input  16  binary16 operand {sign, exp[4:0], frac[9:0]}.
REQ-007 rm  input  1  rounding mode, captured with x: 0 = toward zero, 1 = nearest-even.
REQ-008 out_valid  output  1  result and flags are valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 result  output  16  signed int16 conversion of x.
REQ-011 invalid  output  1  NaN, infinity, or out-of-range input; result is saturated.
REQ-012 inexact  output  1  a nonzero fraction was discarded and the input is not invalid.

Function
REQ-013 An operand SHALL be accepted on a rising edge where in_valid && in_ready; x and rm SHALL be registered on that edge.
REQ-014 FSM states SHALL be IDLE, SHIFT, ROUND, DONE.
REQ-015 IDLE: accept -> SHIFT if 0<=E<=14 and E>0, else -> ROUND; here E = exp-15.
REQ-016 Accumulator acc SHALL be 27 bits, loaded as {15'b0, 1, frac, 1'b0}: integer part in acc[26:11], fraction in acc[10:0].
REQ-017 SHIFT: acc shifts left 1 bit per cycle, E cycles total; after the last shift the FSM goes to ROUND.
REQ-018 ROUND: exactly one cycle; it computes result, invalid and inexact into registers, then the FSM goes to DONE.
REQ-019 Rounding inputs SHALL be: lsb = acc[11], guard = acc[10], sticky = |acc[9:0].
REQ-020 When rm=1, the magnitude SHALL increment if guard && (sticky || lsb).
REQ-021 inexact SHALL equal guard || sticky.
REQ-022 Sign SHALL be applied after rounding, by two's-complement negate.
REQ-023 E<0 with exp!=0:
  - magnitude 0, except rm=1 with E=-1 and frac!=0, which gives magnitude 1;
  - inexact = 1.
REQ-024 exp=0 (zero or subnormal):
  - result = 0;
  - inexact = (frac!=0).
REQ-025 -0 SHALL give 0x0000 with no flags.
REQ-026 exp=31 (inf/NaN), or E>=15 excluding exact -32768:
  - invalid = 1, inexact = 0;
  - result = 0x7FFF for a positive sign or any NaN;
  - result = 0x8000 for a negative non-NaN.
REQ-027 x = 0xF800 SHALL give 0x8000 with no flags.
REQ-028 Latency: out_valid SHALL rise S+2 edges after the accepting edge, where S = E if 0<=E<=14, else S = 0.
REQ-029 DONE: out_valid = 1 and in_ready = 0; result and flags SHALL be held stable until an edge with out_ready=1, which returns the FSM to IDLE.
REQ-030 There SHALL be no same-cycle hand-back: a new operand can be accepted at the earliest one cycle after the result handshake.
REQ-031 in_valid and x changes outside IDLE SHALL be ignored.
REQ-032 out_valid SHALL be 0 in IDLE, SHIFT and ROUND.

Reset
REQ-033 When reset_n=0 at a rising edge, the block SHALL reset as follows:
  - state = IDLE;
  - out_valid = 0, result = 0x0000, invalid = 0, inexact = 0;
  - acc and the shift counter cleared;
  - in_ready = 1 on the following cycle.
REQ-034 Reset SHALL take priority over every handshake and abort any in-flight conversion with no output produced.

Verification
REQ-035 x=0x3C00, rm=0 -> result 0x0001, no flags, out_valid 2 edges after accept; x=0xBC00 -> 0xFFFF.
REQ-036 x=0x4D00 (20.0), rm=0 -> 0x0014, inexact=0, out_valid 6 edges after accept.
REQ-037 Rounding cases:
  - x=0x3E00 (1.5): rm=1 -> 0x0002, inexact=1; rm=0 -> 0x0001, inexact=1;
  - x=0x4100 (2.5): rm=1 -> 0x0002, inexact=1.
REQ-038 Range and special cases:
  - x=0xF800 -> 0x8000, invalid=0;
  - x=0x7800 -> 0x7FFF, invalid=1;
  - x=0x7E00 -> 0x7FFF, invalid=1;
  - x=0xFC00 -> 0x8000, invalid=1;
  - x=0x0001 -> 0x0000, inexact=1.
REQ-039 Back-pressure: out_ready=0 for 5 cycles in DONE with in_valid=1 ->
  - result and flags stable, in_ready=0, no operand accepted;
  - raising out_ready -> IDLE on the next edge, with in_ready=1.
REQ-040 Reset mid-operation: reset_n=0 during SHIFT of x=0x7000 ->
  - next edge: out_valid=0, result=0x0000, in_ready=1;
  - no result is ever emitted for that operand.
